// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt request-capture stage that feeds the
// 8:3 priority encoder.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Handshake FSM: COOL spaces successive interrupts so the encoder output
    // settles before irq_o is raised again.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COOL  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_pending_latch_edge_detect.sv
// Per-line request history register and the edge/level event select.
module irq_edge_detect
    import irq_pkg::*;
#(
    parameter int N    = N_REQ,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] evt
);

    logic [N-1:0] req_q_r;

    // Remember last cycle's request lines; clearing on reset makes a line that
    // is already high at release count as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q_r <= {N{1'b0}};
        end else begin
            req_q_r <= req_i;
        end
    end

    // Choose rising-edge or level events.
    always_comb begin
        evt = {N{1'b0}};
        if (EDGE) begin
            evt = req_i & ~req_q_r;
        end else begin
            evt = req_i;
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending capture, software mask, overflow flag and interrupt
// handshake FSM in front of the combinational 8:3 priority encoder.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N    = N_REQ,
    parameter bit EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             mask_wr,
    input  logic [N-1:0]     mask_din,
    input  logic             ack_i,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovf_clr,
    output logic [N-1:0]     pend_o,
    output logic             irq_o,
    output logic             ovf_o
);

    logic [N-1:0] evt_s;
    logic [N-1:0] pending_r;
    logic [N-1:0] mask_r;
    logic [N-1:0] clr_s;
    logic         ack_ok_s;
    logic         ovf_hit_s;
    logic         ovf_r;
    logic         irq_r;
    irq_state_t   state_r;
    irq_state_t   state_nxt_s;

    irq_edge_detect #(
        .N    (N),
        .EDGE (EDGE)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_i),
        .evt   (evt_s)
    );

    // Masked view is a pure function of registers, so it is glitch-free.
    assign pend_o = pending_r & mask_r;
    assign irq_o  = irq_r;
    assign ovf_o  = ovf_r;

    // Acknowledge acceptance and the one-hot clear it produces; an ack of a
    // hidden or empty bit clears nothing.
    always_comb begin
        ack_ok_s = 1'b0;
        clr_s    = {N{1'b0}};
        if ((state_r == ARMED) && ack_i && pend_o[ack_idx]) begin
            ack_ok_s       = 1'b1;
            clr_s[ack_idx] = 1'b1;
        end else begin
            ack_ok_s = 1'b0;
        end
    end

    // Overflow only has meaning for edge capture; level capture re-hits
    // pending bits every cycle by design.
    always_comb begin
        ovf_hit_s = 1'b0;
        if (EDGE) begin
            ovf_hit_s = |(evt_s & pending_r);
        end else begin
            ovf_hit_s = 1'b0;
        end
    end

    // Pending bits: a new event wins over a same-cycle clear so nothing is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r <= {N{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | evt_s;
        end
    end

    // Mask register, all lines enabled out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_r <= {N{1'b1}};
        end else if (mask_wr) begin
            mask_r <= mask_din;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Sticky overflow; a new hit wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_hit_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Handshake next state. Any ack in ARMED advances to COOL, even a stale
    // one, so the handshake cannot hang.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|pend_o) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED: begin
                if (ack_i) begin
                    state_nxt_s = COOL;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            COOL: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus registered irq decode of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            irq_r   <= (state_nxt_s == ARMED);
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with a behavioural 8:3 priority
// encoder as the consumer and a queue of expected output triples.
module tb_irq_pending_latch;

    typedef struct {
        logic [7:0] pend;
        logic       irq;
        logic       ovf;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       ack_i;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pend_o;
    logic       irq_o;
    logic       ovf_o;
    logic [2:0] enc_e;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    irq_pending_latch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .ack_i    (ack_i),
        .ack_idx  (ack_idx),
        .ovf_clr  (ovf_clr),
        .pend_o   (pend_o),
        .irq_o    (irq_o),
        .ovf_o    (ovf_o)
    );

    // Consumer: highest set bit wins.
    always_comb begin
        enc_e = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_o[i]) enc_e = i[2:0];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expectation, advance one edge, then compare away from the edge.
    task automatic tick(input logic [7:0] p, input logic q, input logic o, input string tag);
        exp_t e;
        exp_t g;
        e.pend = p;
        e.irq  = q;
        e.ovf  = o;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        checks++;
        assert (pend_o === g.pend) else begin
            errors++;
            $error("FAIL %s pend_o got %h exp %h", g.tag, pend_o, g.pend);
        end
        checks++;
        assert (irq_o === g.irq) else begin
            errors++;
            $error("FAIL %s irq_o got %b exp %b", g.tag, irq_o, g.irq);
        end
        checks++;
        assert (ovf_o === g.ovf) else begin
            errors++;
            $error("FAIL %s ovf_o got %b exp %b", g.tag, ovf_o, g.ovf);
        end
    endtask

    task automatic chk_enc(input logic [2:0] exp_e, input string tag);
        checks++;
        assert (enc_e === exp_e) else begin
            errors++;
            $error("FAIL %s enc_e got %0d exp %0d", tag, enc_e, exp_e);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req_i    = 8'h00;
        mask_wr  = 1'b0;
        mask_din = 8'h00;
        ack_i    = 1'b0;
        ack_idx  = 3'd0;
        ovf_clr  = 1'b0;
        tick(8'h00, 1'b0, 1'b0, "reset0");
        tick(8'h00, 1'b0, 1'b0, "reset1");
        rst_n = 1'b1;

        // Single request, two-cycle latency, ack clears it.
        req_i = 8'h01;  tick(8'h01, 1'b0, 1'b0, "req0_set");
        req_i = 8'h00;  tick(8'h01, 1'b1, 1'b0, "req0_irq");
        ack_i = 1'b1; ack_idx = 3'd0;  tick(8'h00, 1'b0, 1'b0, "ack0");
        ack_i = 1'b0;  tick(8'h00, 1'b0, 1'b0, "ack0_idle");
        tick(8'h00, 1'b0, 1'b0, "ack0_stay");

        // Two lines at once, serviced highest first.
        req_i = 8'h82;  tick(8'h82, 1'b0, 1'b0, "req82");
        chk_enc(3'd7, "enc82");
        req_i = 8'h00;  tick(8'h82, 1'b1, 1'b0, "arm82");
        ack_i = 1'b1; ack_idx = enc_e;  tick(8'h02, 1'b0, 1'b0, "ack7");
        ack_i = 1'b0;  tick(8'h02, 1'b0, 1'b0, "gap1");
        tick(8'h02, 1'b1, 1'b0, "rearm1");
        chk_enc(3'd1, "enc02");
        ack_i = 1'b1; ack_idx = enc_e;  tick(8'h00, 1'b0, 1'b0, "ack1");
        ack_i = 1'b0;  tick(8'h00, 1'b0, 1'b0, "ack1_idle");
        tick(8'h00, 1'b0, 1'b0, "ack1_stay");

        // Masked line stays pending but hidden until unmasked.
        mask_wr = 1'b1; mask_din = 8'h7F;  tick(8'h00, 1'b0, 1'b0, "mask7f");
        mask_wr = 1'b0; req_i = 8'h80;  tick(8'h00, 1'b0, 1'b0, "masked_req");
        req_i = 8'h00;  tick(8'h00, 1'b0, 1'b0, "masked_hold");
        mask_wr = 1'b1; mask_din = 8'hFF;  tick(8'h80, 1'b0, 1'b0, "unmask");
        mask_wr = 1'b0;  tick(8'h80, 1'b1, 1'b0, "unmask_irq");
        ack_i = 1'b1; ack_idx = 3'd7;  tick(8'h00, 1'b0, 1'b0, "ack7b");
        ack_i = 1'b0;  tick(8'h00, 1'b0, 1'b0, "ack7b_idle");
        tick(8'h00, 1'b0, 1'b0, "ack7b_stay");

        // Overflow on a repeated edge; one ack is enough.
        req_i = 8'h08;  tick(8'h08, 1'b0, 1'b0, "l3_first");
        req_i = 8'h00;  tick(8'h08, 1'b1, 1'b0, "l3_arm");
        req_i = 8'h08;  tick(8'h08, 1'b1, 1'b1, "ovf_set");
        req_i = 8'h00; ovf_clr = 1'b1;  tick(8'h08, 1'b1, 1'b0, "ovf_clr");
        ovf_clr = 1'b0; ack_i = 1'b1; ack_idx = 3'd3;  tick(8'h00, 1'b0, 1'b0, "ack3");
        ack_i = 1'b0;  tick(8'h00, 1'b0, 1'b0, "ack3_idle");
        tick(8'h00, 1'b0, 1'b0, "ack3_single");

        // New edge racing the ack of the same bit keeps it pending.
        req_i = 8'h10;  tick(8'h10, 1'b0, 1'b0, "l4_set");
        req_i = 8'h00;  tick(8'h10, 1'b1, 1'b0, "l4_arm");
        req_i = 8'h10; ack_i = 1'b1; ack_idx = 3'd4;  tick(8'h10, 1'b0, 1'b1, "l4_race");
        req_i = 8'h00; ack_i = 1'b0;  tick(8'h10, 1'b0, 1'b1, "l4_gap");
        tick(8'h10, 1'b1, 1'b1, "l4_rearm");

        // Reset mid-handshake, request held high across release.
        req_i = 8'hFF;  tick(8'hFF, 1'b1, 1'b1, "all_pend");
        rst_n = 1'b0;  tick(8'h00, 1'b0, 1'b0, "rst_mid");
        tick(8'h00, 1'b0, 1'b0, "rst_hold");
        rst_n = 1'b1;  tick(8'hFF, 1'b0, 1'b0, "rel_edge");
        tick(8'hFF, 1'b1, 1'b0, "rel_arm");
        ack_i = 1'b1; ack_idx = 3'd7;  tick(8'h7F, 1'b0, 1'b0, "rel_ack7");
        ack_i = 1'b0;  tick(8'h7F, 1'b0, 1'b0, "rel_gap");
        tick(8'h7F, 1'b1, 1'b0, "rel_once");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
